srom_stream_reader: RTL

Read sequencer that sits directly in front of the 16x8 single-port SROM. It takes a burst command (start address, length), drives the SROM enable, read-enable and address, and captures the registered read data. Captured words are buffered in a small FIFO and delivered on a valid/ready byte stream with a last-word marker. Backpressure never drops or duplicates a word.

---
 rtl/srom_stream_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/srom_stream_reader.sv
// Burst read sequencer for the 16x8 single-port SROM: issues registered reads,
// buffers the returned words in a small FIFO and streams them out with a last marker.
module srom_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [ADDR_WIDTH-1:0] Start_Address_In,
  input  logic [ADDR_WIDTH:0]   Length_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  Rom_Enable_Out,
  output logic                  Rom_Read_Enable_Out,
  output logic [ADDR_WIDTH-1:0] Rom_Address_Out,
  input  logic [DATA_WIDTH-1:0] Rom_Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  input  logic                  Ready_In,
  output logic                  Last_Out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(2 ** ADDR_WIDTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;

  logic                    fifo_valid;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [CNT_W:0]          occupancy;
  logic [LEN_W-1:0]        len_clamped;

  // Stream handshake: a word transfers on a rising edge where Valid_Out and
  // Ready_In are both high; while Valid_Out is high and Ready_In low, the head
  // word (Data_Out, Last_Out) is held unchanged and Valid_Out stays high.
  always_comb begin
    fifo_valid  = (count_q != '0);
    pop         = fifo_valid & Ready_In;
    push        = inflight_q;
    occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue       = (state_q == ST_FETCH) && (remaining_q != '0) && (occupancy < DEPTH_OCC);
    len_clamped = (Length_In > MAX_LEN) ? MAX_LEN : Length_In;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == LEN_W'(1));
    unique case (state_q)
      ST_IDLE: begin
        if (Start_In) begin
          if (len_clamped != '0) begin
            remaining_d = len_clamped;
            addr_d      = Start_Address_In;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (issue) begin
          remaining_d = remaining_q - LEN_W'(1);
          addr_d      = addr_q + ADDR_WIDTH'(1);
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word is the last one pushed, so once it is popped nothing remains.
        if (!inflight_q && pop && fifo_last_q[rd_ptr_q]) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = Rom_Data_In;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      fifo_last_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      fifo_last_q     <= fifo_last_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= fifo_data_d[i];
    end
  end

  // Read enable also covers the capture cycle, so Rom_Data_In is only sampled while driven.
  always_comb begin
    Busy_Out            = (state_q != ST_IDLE);
    Done_Out            = (state_q == ST_DONE);
    Rom_Enable_Out      = (state_q != ST_IDLE);
    Rom_Read_Enable_Out = issue | inflight_q;
    Rom_Address_Out     = addr_q;
    Data_Out            = fifo_data_q[rd_ptr_q];
    Valid_Out           = fifo_valid;
    Last_Out            = fifo_valid & fifo_last_q[rd_ptr_q];
  end

endmodule
